// File: rtl/seq_sel_pkg.sv
// seq_sel_pkg: shared types and helpers for the serial pattern selector.
package seq_sel_pkg;
  typedef enum logic {FILL, HUNT} state_e;
  function automatic logic [15:0] sel_next(input logic [15:0] sel, input logic [15:0] max);
    return (sel == max) ? 16'd0 : sel + 16'd1;
  endfunction
  function automatic bit params_ok(input int pat_len, input int sel_w, input int sel_max);
    return pat_len >= 2 && pat_len <= 16 && sel_w >= 1 && sel_w <= 16 &&
           sel_max >= 0 && sel_max < (1 << sel_w);
  endfunction
endpackage

// File: rtl/seq_pattern_selector_if.sv
// seq_pattern_selector_if: serial sample inputs and selector outputs of the detector.
interface seq_pattern_selector_if #(parameter int SEL_W = 3);
  logic x;
  logic en;
  logic clr;
  logic [SEL_W-1:0] selsw;
  logic match;
  modport master (output x, en, clr, input selsw, match);
  modport slave (input x, en, clr, output selsw, match);
endinterface

// File: rtl/seq_window.sv
// seq_window: sample window, fill tracking and pattern comparator; hit is combinational.
module seq_window import seq_sel_pkg::*; #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
  input  logic clk,
  input  logic rst,
  input  logic x_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic restart_i,
  output logic hit_o
);
  localparam int FW = $clog2(PAT_LEN);
  localparam logic [FW-1:0] LAST = FW'(PAT_LEN - 1);
  logic [PAT_LEN-1:0] win_q, win_d, win_nx;
  logic [FW-1:0] fill_q, fill_d;
  state_e state_q, state_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
      fill_q <= '0;
      state_q <= FILL;
    end else begin
      win_q <= win_d;
      fill_q <= fill_d;
      state_q <= state_d;
    end
  end
  // HUNT means PAT_LEN-1 samples are already held, so this edge completes a full window.
  always_comb begin
    win_nx = PAT_LEN'({win_q, x_i});
    hit_o = en_i && !clr_i && state_q == HUNT && win_nx == PATTERN;
    win_d = clr_i ? '0 : en_i ? win_nx : win_q;
    fill_d = (clr_i || (en_i && restart_i)) ? '0 :
             (!en_i || fill_q == LAST) ? fill_q : fill_q + 1'b1;
    state_d = (fill_d == LAST) ? HUNT : FILL;
  end
endmodule

// File: rtl/seq_pattern_selector.sv
// seq_pattern_selector: serial pattern detector advancing a wrap-around selector on each match.
module seq_pattern_selector import seq_sel_pkg::*; #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int SEL_W = 3,
  parameter int SEL_MAX = 5,
  parameter bit OVERLAP = 1'b1
) (
  input logic clk,
  input logic reset,
  seq_pattern_selector_if.slave bus
);
  if (!params_ok(PAT_LEN, SEL_W, SEL_MAX)) begin : g_bad_params
    $fatal(1, "seq_pattern_selector: illegal PAT_LEN/SEL_W/SEL_MAX");
  end
  logic hit, restart;
  logic match_q, match_d;
  logic [SEL_W-1:0] selsw_q, selsw_d;
  seq_window #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN)) u_win (
    .clk(clk),
    .rst(reset),
    .x_i(bus.x),
    .en_i(bus.en),
    .clr_i(bus.clr),
    .restart_i(restart),
    .hit_o(hit)
  );
  // Without overlap a hit forces a fresh PAT_LEN-sample fill before the next one.
  always_comb begin
    restart = hit && !OVERLAP;
    match_d = hit;
    selsw_d = bus.clr ? '0 : hit ? SEL_W'(sel_next(16'(selsw_q), 16'(SEL_MAX))) : selsw_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      selsw_q <= '0;
      match_q <= 1'b0;
    end else begin
      selsw_q <= selsw_d;
      match_q <= match_d;
    end
  end
  assign bus.selsw = selsw_q;
  assign bus.match = match_q;
endmodule

// File: tb/tb_seq_pattern_selector.sv
// tb_seq_pattern_selector: directed plus random stimulus on overlap and non-overlap instances vs. a counting model.
module tb_seq_pattern_selector;
  localparam int PL = 4;
  localparam int PAT = 11;
  localparam int SM = 5;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  int cnt[2], hist[2], sel[2], mt[2];
  seq_pattern_selector_if #(.SEL_W(3)) if1 ();
  seq_pattern_selector_if #(.SEL_W(3)) if0 ();
  seq_pattern_selector #(.OVERLAP(1'b1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  seq_pattern_selector #(.OVERLAP(1'b0)) u0 (.clk(clk), .reset(reset), .bus(if0));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " ov1 match"}, 16'(if1.match), 16'(mt[1]));
    check({tag, " ov1 selsw"}, 16'(if1.selsw), 16'(sel[1]));
    check({tag, " ov0 match"}, 16'(if0.match), 16'(mt[0]));
    check({tag, " ov0 selsw"}, 16'(if0.selsw), 16'(sel[0]));
  endtask

  task automatic model_zero();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; hist[i] = 0; sel[i] = 0; mt[i] = 0;
    end
  endtask

  // Index i is the OVERLAP value of the instance being modelled.
  task automatic model_edge(input logic xv, input logic ev, input logic cv);
    if (cv) begin
      model_zero();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      mt[i] = 0;
      if (ev) begin
        hist[i] = (hist[i] * 2 + int'(xv)) % (1 << PL);
        cnt[i]++;
        if (cnt[i] >= PL && hist[i] == PAT) begin
          mt[i] = 1;
          sel[i] = (sel[i] + 1) % (SM + 1);
          if (i == 0) cnt[i] = 0;
        end
      end
    end
  endtask

  task automatic step(input string tag, input logic xv, input logic ev, input logic cv);
    if1.x = xv; if1.en = ev; if1.clr = cv;
    if0.x = xv; if0.en = ev; if0.clr = cv;
    @(posedge clk);
    #1;
    model_edge(xv, ev, cv);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 model_zero();
    check_all(tag);
    #1 reset = 1'b0;
  endtask

  task automatic frame(input string tag);
    step(tag, 1'b1, 1'b1, 1'b0);
    step(tag, 1'b0, 1'b1, 1'b0);
    step(tag, 1'b1, 1'b1, 1'b0);
    step(tag, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    logic [6:0] ovl;
    ovl = 7'b1011011;
    model_zero();
    if1.x = 1'b0; if1.en = 1'b0; if1.clr = 1'b0;
    if0.x = 1'b0; if0.en = 1'b0; if0.clr = 1'b0;
    #1 reset = 1'b1;
    #1 check_all("por");
    #1 reset = 1'b0;
    frame("single");
    check("single ov1 sel=1", 16'(if1.selsw), 16'd1);
    check("single ov1 pulse", 16'(if1.match), 16'd1);
    step("single_end", 1'b0, 1'b0, 1'b0);
    check("single pulse ends", 16'(if1.match), 16'd0);
    step("clr", 1'b0, 1'b0, 1'b1);
    for (int i = 6; i >= 0; i--) step("overlap", ovl[i], 1'b1, 1'b0);
    check("overlap ov1 sel=2", 16'(if1.selsw), 16'd2);
    check("overlap ov0 sel=1", 16'(if0.selsw), 16'd1);
    step("clr", 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 6; f++) frame($sformatf("wrap%0d", f));
    check("wrap ov1 sel=0", 16'(if1.selsw), 16'd0);
    check("wrap ov1 pulse", 16'(if1.match), 16'd1);
    step("clr", 1'b0, 1'b0, 1'b1);
    step("gap", 1'b1, 1'b1, 1'b0);
    step("gap", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("gap_off", 1'b0, 1'b0, 1'b0);
    step("gap", 1'b1, 1'b1, 1'b0);
    step("gap", 1'b1, 1'b1, 1'b0);
    check("gap ov0 sel=1", 16'(if0.selsw), 16'd1);
    step("clr", 1'b0, 1'b0, 1'b1);
    step("midclr", 1'b1, 1'b1, 1'b0);
    step("midclr", 1'b0, 1'b1, 1'b0);
    step("midclr", 1'b1, 1'b1, 1'b0);
    step("midclr_clr", 1'b1, 1'b1, 1'b1);
    step("midclr", 1'b1, 1'b1, 1'b0);
    check("midclr no match", 16'(if1.match), 16'd0);
    step("midrst", 1'b1, 1'b1, 1'b0);
    step("midrst", 1'b0, 1'b1, 1'b0);
    step("midrst", 1'b1, 1'b1, 1'b0);
    async_reset("midrst_async");
    step("midrst", 1'b1, 1'b1, 1'b0);
    check("midrst no match", 16'(if0.match), 16'd0);
    frame("after_rst");
    check("after_rst ov0 sel=1", 16'(if0.selsw), 16'd1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      else step("rnd", 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 8,
                $urandom_range(0, 39) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
